// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel edge engine.
package sobel_pkg;

    // Bits the gradient sums grow beyond the pixel width (x4 weight sum plus sign).
    localparam int GRAD_GROWTH = 3;
    // Pixel width of the reference configuration.
    localparam int DATA_W_DEF  = 8;
    // Signed gradient width for the reference configuration.
    localparam int GRAD_W      = DATA_W_DEF + GRAD_GROWTH;

    // Output mode encodings.
    localparam int MODE_MAG = 0;
    localparam int MODE_BIN = 1;

    // Clamp a value to an upper bound.
    function automatic logic [31:0] saturate(input logic [31:0] i_val, input logic [31:0] i_max);
        logic [31:0] w_res;
        if (i_val > i_max) begin
            w_res = i_max;
        end else begin
            w_res = i_val;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/sobel_stream_pipe_line_buffer.sv
// One raster line of pixel storage; reading returns the value written one line ago.
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 320,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // Old contents leave combinationally, so a same-address write never bypasses.
    assign o_data = r_mem[i_addr];

    // Store the new pixel over the one just read when a pixel is accepted.
    always_ff @(posedge clock) begin
        if (i_en) begin
            r_mem[i_addr] <= i_data;
        end
    end

endmodule

// File: rtl/sobel_stream_pipe.sv
// Streaming 3x3 Sobel engine: line buffers build the window, then a free-running
// gradient / magnitude / result pipeline emits one value per interior pixel.
module sobel_stream_pipe
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 256,
    parameter int MODE   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_reset,
    input  logic [DATA_W-1:0] datain,
    input  logic              datain_en,
    input  logic [DATA_W-1:0] threshold,
    output logic [DATA_W-1:0] dataout,
    output logic              dataout_valid,
    output logic              dataout_eol,
    output logic              dataout_eof
);

    localparam int L_GRAD_W = DATA_W + GRAD_GROWTH;
    localparam int L_MAG_W  = L_GRAD_W + 1;
    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [DATA_W-1:0]   r_win [0:8];
    logic                r_s1_vld, r_s1_eol, r_s1_eof;
    logic [L_GRAD_W-1:0] r_gx, r_gy;
    logic                r_s2_vld, r_s2_eol, r_s2_eof;
    logic [L_MAG_W-1:0]  r_mag;
    logic                r_s3_vld, r_s3_eol, r_s3_eof;

    logic                w_accept;
    logic                w_interior;
    logic [DATA_W-1:0]   w_lb1_q, w_lb2_q;
    logic [L_GRAD_W-1:0] w_gx, w_gy;
    logic [L_GRAD_W-1:0] w_abs_gx, w_abs_gy;
    logic [L_MAG_W-1:0]  w_mag;
    logic [DATA_W-1:0]   w_result;

    // A pixel offered during a frame realignment is dropped.
    assign w_accept   = datain_en & ~frame_reset;
    assign w_interior = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    // Raster position of the next accepted pixel; wraps into the next frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (frame_reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (datain_en) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Row r-1 lives in the first buffer; its evicted pixels become row r-2 in the second.
    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb1 (
        .clock  (clock),
        .i_en   (w_accept),
        .i_addr (r_col),
        .i_data (datain),
        .o_data (w_lb1_q)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb2 (
        .clock  (clock),
        .i_en   (w_accept),
        .i_addr (r_col),
        .i_data (w_lb1_q),
        .o_data (w_lb2_q)
    );

    // Shift the 3x3 window left and load the new right column on each accepted pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_accept) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_lb2_q;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_lb1_q;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= datain;
        end
    end

    // Tag the freshly loaded window as a valid interior result and note its line/frame end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
            r_s1_eol <= 1'b0;
            r_s1_eof <= 1'b0;
        end else if (frame_reset) begin
            r_s1_vld <= 1'b0;
            r_s1_eol <= 1'b0;
            r_s1_eof <= 1'b0;
        end else begin
            r_s1_vld <= w_accept & w_interior;
            r_s1_eol <= w_accept & w_interior & (r_col == COL_LAST);
            r_s1_eof <= w_accept & w_interior & (r_col == COL_LAST) & (r_row == ROW_LAST);
        end
    end

    // Two's-complement gradients; operands are zero-extended so the wrap yields the signed value.
    assign w_gx = (L_GRAD_W'(r_win[2]) + L_GRAD_W'({r_win[5], 1'b0}) + L_GRAD_W'(r_win[8]))
                - (L_GRAD_W'(r_win[0]) + L_GRAD_W'({r_win[3], 1'b0}) + L_GRAD_W'(r_win[6]));
    assign w_gy = (L_GRAD_W'(r_win[6]) + L_GRAD_W'({r_win[7], 1'b0}) + L_GRAD_W'(r_win[8]))
                - (L_GRAD_W'(r_win[0]) + L_GRAD_W'({r_win[1], 1'b0}) + L_GRAD_W'(r_win[2]));

    // Register gradients every cycle; only the valid bit qualifies them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_gx     <= '0;
            r_gy     <= '0;
            r_s2_vld <= 1'b0;
            r_s2_eol <= 1'b0;
            r_s2_eof <= 1'b0;
        end else if (frame_reset) begin
            r_gx     <= w_gx;
            r_gy     <= w_gy;
            r_s2_vld <= 1'b0;
            r_s2_eol <= 1'b0;
            r_s2_eof <= 1'b0;
        end else begin
            r_gx     <= w_gx;
            r_gy     <= w_gy;
            r_s2_vld <= r_s1_vld;
            r_s2_eol <= r_s1_eol;
            r_s2_eof <= r_s1_eof;
        end
    end

    // |gx| + |gy|; the most negative code cannot occur, so negation never overflows.
    assign w_abs_gx = r_gx[L_GRAD_W-1] ? (~r_gx + 1'b1) : r_gx;
    assign w_abs_gy = r_gy[L_GRAD_W-1] ? (~r_gy + 1'b1) : r_gy;
    assign w_mag    = L_MAG_W'(w_abs_gx) + L_MAG_W'(w_abs_gy);

    // Register the magnitude and carry the qualifiers alongside.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mag    <= '0;
            r_s3_vld <= 1'b0;
            r_s3_eol <= 1'b0;
            r_s3_eof <= 1'b0;
        end else if (frame_reset) begin
            r_mag    <= w_mag;
            r_s3_vld <= 1'b0;
            r_s3_eol <= 1'b0;
            r_s3_eof <= 1'b0;
        end else begin
            r_mag    <= w_mag;
            r_s3_vld <= r_s2_vld;
            r_s3_eol <= r_s2_eol;
            r_s3_eof <= r_s2_eof;
        end
    end

    // Final value: saturated magnitude, or a binary edge against the live threshold.
    always_comb begin
        w_result = '0;
        if (MODE == MODE_BIN) begin
            if (r_mag > L_MAG_W'(threshold)) begin
                w_result = {DATA_W{1'b1}};
            end else begin
                w_result = '0;
            end
        end else begin
            w_result = DATA_W'(saturate(32'(r_mag), 32'({DATA_W{1'b1}})));
        end
    end

    // Registered outputs; data and markers read zero whenever no result is presented.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dataout       <= '0;
            dataout_valid <= 1'b0;
            dataout_eol   <= 1'b0;
            dataout_eof   <= 1'b0;
        end else if (frame_reset) begin
            dataout       <= '0;
            dataout_valid <= 1'b0;
            dataout_eol   <= 1'b0;
            dataout_eof   <= 1'b0;
        end else begin
            dataout       <= r_s3_vld ? w_result : '0;
            dataout_valid <= r_s3_vld;
            dataout_eol   <= r_s3_eol;
            dataout_eof   <= r_s3_eof;
        end
    end

endmodule

// File: tb/tb_sobel_stream_pipe.sv
// Scoreboard bench: an image-array reference model predicts every result and the
// cycle it must appear; a negedge monitor checks both output modes against it.
module tb_sobel_stream_pipe;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 6;
    localparam int N_OUT  = (IMG_W - 2) * (IMG_H - 2);

    logic              clock = 1'b0;
    logic              reset;
    logic              frame_reset;
    logic [DATA_W-1:0] datain;
    logic              datain_en;
    logic [DATA_W-1:0] threshold;
    logic [DATA_W-1:0] dout_m, dout_b;
    logic              vld_m, eol_m, eof_m;
    logic              vld_b, eol_b, eof_b;

    typedef struct {
        int cyc;
        int mag;
        bit eol;
        bit eof;
        int thr;
    } exp_t;

    exp_t q[$];
    int   img [IMG_H][IMG_W];
    int   mrow, mcol, cur_thr;
    int   cyc    = 0;
    int   n_out  = 0;
    int   checks = 0;
    int   errors = 0;

    sobel_stream_pipe #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .MODE(0)) dut_mag (
        .clock(clock), .reset(reset), .frame_reset(frame_reset),
        .datain(datain), .datain_en(datain_en), .threshold(threshold),
        .dataout(dout_m), .dataout_valid(vld_m), .dataout_eol(eol_m), .dataout_eof(eof_m)
    );

    sobel_stream_pipe #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .MODE(1)) dut_bin (
        .clock(clock), .reset(reset), .frame_reset(frame_reset),
        .datain(datain), .datain_en(datain_en), .threshold(threshold),
        .dataout(dout_b), .dataout_valid(vld_b), .dataout_eol(eol_b), .dataout_eof(eof_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: record the pixel in the image, and if it completes an interior
    // window compute the Sobel magnitude directly from the stored neighbourhood.
    task automatic model_accept(input int pix, input int k);
        int gx, gy, r, c;
        exp_t e;
        r = mrow;
        c = mcol;
        img[r][c] = pix;
        if (r >= 2 && c >= 2) begin
            gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
            gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
            e.cyc = k + 4;
            e.mag = iabs(gx) + iabs(gy);
            e.eol = (c == IMG_W - 1);
            e.eof = (c == IMG_W - 1) && (r == IMG_H - 1);
            e.thr = cur_thr;
            q.push_back(e);
        end
        if (c == IMG_W - 1) begin
            mcol = 0;
            mrow = (r == IMG_H - 1) ? 0 : r + 1;
        end else begin
            mcol = c + 1;
        end
    endtask

    // One input cycle; inputs change 1 time unit after the edge and apply at the next edge.
    task automatic drive(input bit en, input int pix, input bit fr);
        @(posedge clock);
        #1;
        datain_en   = en;
        datain      = DATA_W'(pix);
        frame_reset = fr;
        if (fr) begin
            while (q.size() > 0 && q[q.size()-1].cyc > cyc) q.delete(q.size() - 1);
            mrow = 0;
            mcol = 0;
        end else if (en) begin
            model_accept(pix, cyc);
        end
    endtask

    function automatic int pix_of(input int kind, input int c);
        case (kind)
            0:       return 77;
            1:       return 10 * c;
            2:       return (c < 4) ? 0 : 100;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic send_pixels(input int kind, input bit gaps, input int count);
        for (int n = 0; n < count; n++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) drive(1'b0, 0, 1'b0);
            end
            drive(1'b1, pix_of(kind, mcol), 1'b0);
        end
    endtask

    task automatic set_thr(input int t);
        cur_thr   = t;
        threshold = DATA_W'(t);
    endtask

    // Let the pipeline drain, then confirm the frame yielded exactly the predicted outputs.
    task automatic finish_frame(input string name, input int n_start);
        repeat (8) drive(1'b0, 0, 1'b0);
        check({name, "_count"}, n_out - n_start, N_OUT);
        check({name, "_queue_empty"}, q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_mag_data"},  int'(dout_m), 0);
        check({name, "_mag_valid"}, int'(vld_m), 0);
        check({name, "_mag_eol"},   int'(eol_m), 0);
        check({name, "_mag_eof"},   int'(eof_m), 0);
        check({name, "_bin_data"},  int'(dout_b), 0);
        check({name, "_bin_valid"}, int'(vld_b), 0);
        check({name, "_bin_eol"},   int'(eol_b), 0);
        check({name, "_bin_eof"},   int'(eof_b), 0);
    endtask

    // Monitor: each presented result is matched against the oldest prediction.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (vld_m) begin
                n_out++;
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("latency_cycle", cyc, e.cyc);
                    check("mag_data", int'(dout_m), (e.mag > 255) ? 255 : e.mag);
                    check("mag_eol", int'(eol_m), int'(e.eol));
                    check("mag_eof", int'(eof_m), int'(e.eof));
                    check("bin_valid", int'(vld_b), 1);
                    check("bin_data", int'(dout_b), (e.mag > e.thr) ? 255 : 0);
                    check("bin_eol", int'(eol_b), int'(e.eol));
                    check("bin_eof", int'(eof_b), int'(e.eof));
                end
            end else begin
                if (vld_b || eol_m || eof_m || eol_b || eof_b) begin
                    check("idle_flags", 1, 0);
                end
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    check("missing_output_cycle", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int n0;
        reset       = 1'b1;
        frame_reset = 1'b0;
        datain      = '0;
        datain_en   = 1'b0;
        mrow        = 0;
        mcol        = 0;
        set_thr(0);
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset_state");
        reset = 1'b0;

        // Constant image: all-zero gradients, markers still tracked.
        n0 = n_out;
        send_pixels(0, 1'b0, IMG_W * IMG_H);
        finish_frame("const", n0);

        // Horizontal ramp, both modes (binary with threshold 254).
        set_thr(254);
        n0 = n_out;
        send_pixels(1, 1'b0, IMG_W * IMG_H);
        finish_frame("ramp", n0);

        // Vertical step, saturating edges at centres 3 and 4.
        n0 = n_out;
        send_pixels(2, 1'b0, IMG_W * IMG_H);
        finish_frame("step", n0);

        // Ramp against the maximum threshold.
        set_thr(255);
        n0 = n_out;
        send_pixels(1, 1'b0, IMG_W * IMG_H);
        finish_frame("ramp_thr255", n0);

        // Ramp with random enable gaps.
        set_thr(60);
        n0 = n_out;
        send_pixels(1, 1'b1, IMG_W * IMG_H);
        finish_frame("ramp_gaps", n0);

        // Random images with gaps and random thresholds.
        for (int f = 0; f < 3; f++) begin
            set_thr(int'($urandom_range(0, 255)));
            n0 = n_out;
            send_pixels(3, 1'b1, IMG_W * IMG_H);
            finish_frame("random", n0);
        end

        // Frame realignment after 20 pixels, with a pixel offered in the same cycle.
        send_pixels(3, 1'b0, 20);
        drive(1'b1, 200, 1'b1);
        n0 = n_out;
        send_pixels(3, 1'b0, IMG_W * IMG_H);
        finish_frame("after_frame_reset", n0);

        // Asynchronous reset while results are flowing.
        send_pixels(3, 1'b0, 4 * IMG_W + 3);
        @(posedge clock);
        #1;
        reset     = 1'b1;
        datain_en = 1'b0;
        q.delete();
        mrow = 0;
        mcol = 0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) begin
            @(posedge clock);
            #1;
            check_outputs_zero("held_reset");
        end
        reset = 1'b0;
        n0 = n_out;
        send_pixels(3, 1'b1, IMG_W * IMG_H);
        finish_frame("after_reset", n0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete (checks %0d)", checks);
        $fatal(1);
    end

endmodule
